// File: rtl/norm_seq_ctrl.sv
// Sequencer for the norm datapath: loads a vector into norm, issues paced divides
// and returns indexed results. Optional perf counters under NORM_SEQ_CTRL_PERF_EN.
module norm_seq_ctrl #(
    parameter int BW      = 4,
    parameter int TOTAL   = 8,
    parameter int IW      = 3,
    parameter int DIV_LAT = 1,
    parameter int DIV_GAP = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [BW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BW-1:0]   norm_in,
    output logic            norm_wr,
    output logic            norm_div,
    input  logic [2*BW-1:0] norm_out,
    output logic [2*BW-1:0] out_data,
    output logic [IW-1:0]   out_idx,
    output logic            out_valid,
    input  logic            out_ready
`ifdef NORM_SEQ_CTRL_PERF_EN
    ,
    output logic [15:0]     perf_cycles,
    output logic [15:0]     perf_stall
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_DIV    = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int GW = (DIV_GAP > 1) ? $clog2(DIV_GAP + 1) : 1;
    localparam int LW = (DIV_LAT > 1) ? $clog2(DIV_LAT + 1) : 1;

    localparam logic [IW:0] TOTAL_C = (IW+1)'(TOTAL);
    localparam logic [IW:0] LAST_C  = (IW+1)'(TOTAL - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [IW:0]   wcnt;
    logic [IW:0]   rcnt;
    logic [GW-1:0] gap_cnt;
    logic [LW-1:0] lat_cnt;
    logic          lat_pend;

    logic in_hs;
    logic out_hs;
    logic gap_done;
    logic release_ok;
    logic last_result;

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign norm_div = (state == S_DIV);
    // in_ready drops once all writes are accepted so the final norm_wr cycle
    // stays in LOAD and SETTLE itself is a clean wr=0/div=0 cycle.
    assign in_ready = (state == S_LOAD) && (wcnt != TOTAL_C);

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // gap_cnt is loaded during DIV; the DIV cycle itself counts toward the gap.
    assign gap_done    = (gap_cnt <= GW'(1));
    assign release_ok  = gap_done && !lat_pend && (!out_valid || out_ready);
    assign last_result = out_hs ? (rcnt == LAST_C) : (rcnt == TOTAL_C);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   if (wcnt == TOTAL_C) state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_DIV;
            S_DIV:    state_nxt = S_WAIT;
            S_WAIT:   if (release_ok) state_nxt = last_result ? S_DONE : S_DIV;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            rcnt      <= '0;
            gap_cnt   <= '0;
            lat_cnt   <= '0;
            lat_pend  <= 1'b0;
            norm_in   <= '0;
            norm_wr   <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            norm_wr <= in_hs;

            if (state == S_IDLE && start) begin
                wcnt <= '0;
                rcnt <= '0;
            end

            if (in_hs) begin
                norm_in <= in_data;
                wcnt    <= wcnt + 1'b1;
            end

            if (state == S_DIV) begin
                gap_cnt  <= GW'(DIV_GAP - 1);
                lat_cnt  <= LW'(DIV_LAT - 1);
                lat_pend <= 1'b1;
            end

            if (state == S_WAIT) begin
                if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                if (lat_pend) begin
                    if (lat_cnt == '0) begin
                        lat_pend <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
            end

            if (out_hs) begin
                out_valid <= 1'b0;
                rcnt      <= rcnt + 1'b1;
            end

            // Capture is placed last; it cannot coincide with a handshake since
            // div is only issued once the previous result has left.
            if (state == S_WAIT && lat_pend && lat_cnt == '0) begin
                out_data  <= norm_out;
                out_idx   <= rcnt[IW-1:0];
                out_valid <= 1'b1;
            end
        end
    end

`ifdef NORM_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state == S_IDLE && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
            if (out_valid && !out_ready && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Directed self-checking bench for norm_seq_ctrl with a behavioural norm model.
// Perf counter checks are compiled in when NORM_SEQ_CTRL_PERF_EN is defined.
module tb_norm_seq_ctrl;

    localparam int BW    = 4;
    localparam int TOTAL = 8;
    localparam int IW    = 3;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, out_ready;
    logic [BW-1:0] in_data;
    logic          busy, done, in_ready, norm_wr, norm_div, out_valid;
    logic [BW-1:0] norm_in;
    logic [7:0]    norm_out, out_data;
    logic [IW-1:0] out_idx;
`ifdef NORM_SEQ_CTRL_PERF_EN
    logic [15:0]   perf_cycles, perf_stall;
`endif

    always #5 clk = ~clk;

    norm_seq_ctrl #(.BW(BW), .TOTAL(TOTAL), .IW(IW), .DIV_LAT(1), .DIV_GAP(7)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .norm_in(norm_in), .norm_wr(norm_wr), .norm_div(norm_div), .norm_out(norm_out),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
`ifdef NORM_SEQ_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] vec[8];
    logic [3:0] wr_q[$];
    int         wr_cyc_q[$];
    int         div_cyc_q[$];
    logic [7:0] od_q[$];
    logic [2:0] oi_q[$];
    int         hs_cyc_q[$];
    int         done_cnt, done_cyc, start_cyc, stall_cnt;

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (norm_wr) begin wr_q.push_back(norm_in); wr_cyc_q.push_back(cyc); end
            if (norm_div) div_cyc_q.push_back(cyc);
            if (out_valid && out_ready) begin
                od_q.push_back(out_data); oi_q.push_back(out_idx); hs_cyc_q.push_back(cyc);
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (start && !busy) start_cyc = cyc;
        end
        cyc++;
    end

    // norm model: stores writes; result of the k-th divide is {k, element k},
    // valid only for the single cycle after the divide edge.
    logic [3:0] nm_mem[8];
    int         nm_w, nm_k;
    always @(posedge clk) begin
        if (reset) begin
            nm_w = 0; nm_k = 0;
            norm_out <= 8'h00;
        end else begin
            if (norm_wr) begin nm_mem[nm_w % 8] = norm_in; nm_w++; end
            if (norm_div) begin
                norm_out <= {4'(nm_k), nm_mem[nm_k % 8]};
                nm_k++;
            end else begin
                norm_out <= 8'hEE;
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic clear_logs;
        wr_q.delete(); wr_cyc_q.delete(); div_cyc_q.delete();
        od_q.delete(); oi_q.delete(); hs_cyc_q.delete();
        done_cnt = 0; done_cyc = -1; start_cyc = -1; stall_cnt = 0;
    endtask

    task automatic apply_reset;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step; step;
        reset = 1'b0;
        clear_logs;
    endtask

    task automatic set_vec(input logic [31:0] p);
        for (int i = 0; i < 8; i++) vec[i] = p[4*i +: 4];
    endtask

    task automatic do_start;
        start = 1'b1; step; start = 1'b0;
    endtask

    task automatic feed(input int bub_at, input int bub_len, input int start_at,
                        output int accepted, output int ready_drops);
        int i = 0, left = 0, guard = 0;
        bit pulsed = 0;
        ready_drops = 0;
        while (i < TOTAL && guard < 300) begin
            if (start_at >= 0 && i == start_at && !pulsed) begin start = 1'b1; pulsed = 1; end
            else start = 1'b0;
            if (left > 0) in_valid = 1'b0;
            else begin in_valid = 1'b1; in_data = vec[i]; end
            @(negedge clk);
            if (in_valid && in_ready) begin
                i++;
                if (i == bub_at) left = bub_len;
            end else if (!in_valid && left > 0) begin
                left--;
                if (!in_ready) ready_drops++;
            end
            step; guard++;
        end
        in_valid = 1'b0; start = 1'b0;
        accepted = i;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin step; n++; end
        step; step;
    endtask

    task automatic test_reset;
        logic [27:0] outs;
        apply_reset;
        outs = {busy, done, in_ready, norm_wr, norm_div, out_valid, norm_in, out_data, out_idx};
        n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
`ifdef NORM_SEQ_CTRL_PERF_EN
        n_checks++; if ({perf_cycles, perf_stall} !== 32'h0) begin n_fail++;
            $display("FAIL reset_perf: got %h expected 0", {perf_cycles, perf_stall}); end
`endif
    endtask

    task automatic test_basic;
        int acc, drops;
        apply_reset;
        set_vec(32'h8765_4321);
        do_start;
        feed(-1, 0, -1, acc, drops);
        wait_done(200);
        n_checks++; if (acc !== 8) begin n_fail++; $display("FAIL basic_accepted: got %0d expected 8", acc); end
        n_checks++; if (wr_q.size() !== 8) begin n_fail++; $display("FAIL basic_wr_count: got %0d expected 8", wr_q.size()); end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_checks++; if (wr_q[i] !== vec[i]) begin n_fail++;
                $display("FAIL basic_wr_data[%0d]: got %h expected %h", i, wr_q[i], vec[i]); end
        end
        if (wr_cyc_q.size() == 8) begin
            n_checks++; if (wr_cyc_q[7] - wr_cyc_q[0] !== 7) begin n_fail++;
                $display("FAIL basic_wr_contig: got %0d expected 7", wr_cyc_q[7] - wr_cyc_q[0]); end
        end
        n_checks++; if (div_cyc_q.size() !== 8) begin n_fail++; $display("FAIL basic_div_count: got %0d expected 8", div_cyc_q.size()); end
        if (div_cyc_q.size() == 8 && wr_cyc_q.size() == 8) begin
            n_checks++; if (div_cyc_q[0] - wr_cyc_q[7] !== 2) begin n_fail++;
                $display("FAIL basic_settle: got %0d expected 2", div_cyc_q[0] - wr_cyc_q[7]); end
            for (int k = 1; k < 8; k++) begin
                n_checks++; if (div_cyc_q[k] - div_cyc_q[k-1] !== 7) begin n_fail++;
                    $display("FAIL basic_div_gap[%0d]: got %0d expected 7", k, div_cyc_q[k] - div_cyc_q[k-1]); end
            end
        end
        n_checks++; if (od_q.size() !== 8) begin n_fail++; $display("FAIL basic_out_count: got %0d expected 8", od_q.size()); end
        for (int i = 0; i < 8 && i < od_q.size(); i++) begin
            n_checks++; if (oi_q[i] !== 3'(i) || od_q[i] !== {4'(i), vec[i]}) begin n_fail++;
                $display("FAIL basic_out[%0d]: got idx %0d data %h expected idx %0d data %h",
                         i, oi_q[i], od_q[i], i, {4'(i), vec[i]}); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_cyc - start_cyc !== 67) begin n_fail++;
            $display("FAIL basic_latency: got %0d expected 67", done_cyc - start_cyc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy %b expected 0", busy); end
`ifdef NORM_SEQ_CTRL_PERF_EN
        step; step;
        n_checks++; if (perf_cycles !== 16'(done_cyc - start_cyc)) begin n_fail++;
            $display("FAIL perf_cycles: got %0d expected %0d", perf_cycles, done_cyc - start_cyc); end
        n_checks++; if (perf_stall !== 16'd0) begin n_fail++; $display("FAIL perf_stall_clean: got %0d expected 0", perf_stall); end
`endif
    endtask

    task automatic test_bubble;
        int acc, drops;
        apply_reset;
        set_vec(32'h3C96_A5E1);
        do_start;
        feed(2, 3, -1, acc, drops);
        wait_done(200);
        n_checks++; if (wr_q.size() !== 8) begin n_fail++; $display("FAIL bubble_wr_count: got %0d expected 8", wr_q.size()); end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_checks++; if (wr_q[i] !== vec[i]) begin n_fail++;
                $display("FAIL bubble_wr_data[%0d]: got %h expected %h", i, wr_q[i], vec[i]); end
        end
        if (wr_cyc_q.size() == 8) begin
            n_checks++; if (wr_cyc_q[2] - wr_cyc_q[1] !== 4) begin n_fail++;
                $display("FAIL bubble_gap: got %0d expected 4", wr_cyc_q[2] - wr_cyc_q[1]); end
        end
        n_checks++; if (drops !== 0) begin n_fail++; $display("FAIL bubble_in_ready: got %0d drops expected 0", drops); end
        n_checks++; if (od_q.size() !== 8) begin n_fail++; $display("FAIL bubble_out_count: got %0d expected 8", od_q.size()); end
        if (od_q.size() == 8) begin
            n_checks++; if (od_q[7] !== {4'd7, vec[7]}) begin n_fail++;
                $display("FAIL bubble_out_last: got %h expected %h", od_q[7], {4'd7, vec[7]}); end
        end
    endtask

    task automatic test_backpressure;
        int acc, drops, n, unstable, div_during;
        logic [7:0] d0;
        logic [2:0] i0;
        apply_reset;
        set_vec(32'h8765_4321);
        do_start;
        feed(-1, 0, -1, acc, drops);
        n = 0;
        while (od_q.size() < 3 && n < 200) begin step; n++; end
        out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 100);
        n_checks++; if (!out_valid) begin n_fail++; $display("FAIL bp_valid_timeout: got 0 expected 1"); end
        d0 = out_data; i0 = out_idx; unstable = 0;
        repeat (19) begin
            @(negedge clk);
            if (out_data !== d0 || out_idx !== i0 || !out_valid) unstable++;
        end
        div_during = div_cyc_q.size();
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(200);
        n_checks++; if (i0 !== 3'd3) begin n_fail++; $display("FAIL bp_idx: got %0d expected 3", i0); end
        n_checks++; if (d0 !== {4'd3, vec[3]}) begin n_fail++; $display("FAIL bp_data: got %h expected %h", d0, {4'd3, vec[3]}); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
        n_checks++; if (div_during !== 4) begin n_fail++; $display("FAIL bp_no_div: got %0d divs expected 4", div_during); end
        n_checks++; if (stall_cnt !== 20) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 20", stall_cnt); end
        if (div_cyc_q.size() >= 5 && hs_cyc_q.size() >= 4) begin
            n_checks++; if (div_cyc_q[4] <= hs_cyc_q[3]) begin n_fail++;
                $display("FAIL bp_div_after_hs: got div %0d expected > %0d", div_cyc_q[4], hs_cyc_q[3]); end
        end
        n_checks++; if (od_q.size() !== 8) begin n_fail++; $display("FAIL bp_out_count: got %0d expected 8", od_q.size()); end
        for (int i = 0; i < 8 && i < od_q.size(); i++) begin
            n_checks++; if (oi_q[i] !== 3'(i) || od_q[i] !== {4'(i), vec[i]}) begin n_fail++;
                $display("FAIL bp_out[%0d]: got idx %0d data %h expected data %h", i, oi_q[i], od_q[i], {4'(i), vec[i]}); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
`ifdef NORM_SEQ_CTRL_PERF_EN
        n_checks++; if (perf_stall !== 16'd20) begin n_fail++; $display("FAIL perf_stall_bp: got %0d expected 20", perf_stall); end
`endif
    endtask

    task automatic test_start_busy;
        int acc, drops, n;
        apply_reset;
        set_vec(32'h1357_9BDF);
        do_start;
        feed(-1, 0, 4, acc, drops);
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) step;
        n_checks++; if (n >= 300) begin n_fail++; $display("FAIL sb_done_timeout: got timeout expected done"); end
        n_checks++; if (wr_q.size() !== 8) begin n_fail++; $display("FAIL sb_wr_count: got %0d expected 8", wr_q.size()); end
        n_checks++; if (div_cyc_q.size() !== 8) begin n_fail++; $display("FAIL sb_div_count: got %0d expected 8", div_cyc_q.size()); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL sb_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sb_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int acc, drops, n;
        logic [27:0] outs;
        apply_reset;
        set_vec(32'h8765_4321);
        do_start;
        feed(-1, 0, -1, acc, drops);
        n = 0;
        while (div_cyc_q.size() < 6 && n < 200) begin step; n++; end
        reset = 1'b1;
        step;
        reset = 1'b0;
        outs = {busy, done, in_ready, norm_wr, norm_div, out_valid, norm_in, out_data, out_idx};
        n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL rm_outputs: got %h expected 0", outs); end
        clear_logs;
        set_vec(32'h0F1E_2D3C);
        do_start;
        feed(-1, 0, -1, acc, drops);
        wait_done(200);
        n_checks++; if (wr_q.size() !== 8) begin n_fail++; $display("FAIL rm_wr_count: got %0d expected 8", wr_q.size()); end
        n_checks++; if (od_q.size() !== 8) begin n_fail++; $display("FAIL rm_out_count: got %0d expected 8", od_q.size()); end
        for (int i = 0; i < 8 && i < od_q.size(); i++) begin
            n_checks++; if (oi_q[i] !== 3'(i) || od_q[i] !== {4'(i), vec[i]}) begin n_fail++;
                $display("FAIL rm_out[%0d]: got idx %0d data %h expected data %h", i, oi_q[i], od_q[i], {4'(i), vec[i]}); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rm_done_count: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        test_reset;
        test_basic;
        test_bubble;
        test_backpressure;
        test_start_busy;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
